// File: rtl/apb_uart.sv
// APB-slave UART: register file, TX and RX frame engines, RTS/CTS handshake.
module apb_uart_top #(
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FREQUENCY_CLK = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  pstrb,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        rx,
  output logic        tx,
  input  logic        cts_n,
  output logic        rts_n
);

  localparam int unsigned BIT_CYC  = FREQUENCY_CLK / BAUD_RATE;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);

  localparam logic [11:0] ADDR_TX_DATA = 12'h000;
  localparam logic [11:0] ADDR_RX_DATA = 12'h004;
  localparam logic [11:0] ADDR_CFG     = 12'h008;
  localparam logic [11:0] ADDR_CTRL    = 12'h00C;
  localparam logic [11:0] ADDR_STATUS  = 12'h010;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_e;

  // ---------------- APB decode ----------------
  logic access_c, mapped_c, wr_en_c, start_req_c, rx_rd_clr_c, tx_busy_c;
  logic sel_tx_c, sel_rx_c, sel_cfg_c, sel_ctrl_c, sel_stat_c;
  logic unused_bits;

  logic [7:0] tx_data_q;
  logic [4:0] cfg_q;
  logic       ctrl_q;

  assign sel_tx_c    = (paddr == ADDR_TX_DATA);
  assign sel_rx_c    = (paddr == ADDR_RX_DATA);
  assign sel_cfg_c   = (paddr == ADDR_CFG);
  assign sel_ctrl_c  = (paddr == ADDR_CTRL);
  assign sel_stat_c  = (paddr == ADDR_STATUS);
  assign mapped_c    = sel_tx_c | sel_rx_c | sel_cfg_c | sel_ctrl_c | sel_stat_c;
  assign access_c    = psel & penable;
  assign wr_en_c     = access_c & pwrite & mapped_c & pstrb[0];
  assign start_req_c = wr_en_c & sel_ctrl_c & pwdata[0] & ~tx_busy_c;
  assign rx_rd_clr_c = access_c & ~pwrite & sel_rx_c;
  assign pready      = 1'b1;
  assign pslverr     = access_c & ~mapped_c;
  assign unused_bits = ^{pwdata[31:8], pstrb[3:1]};

  // Writable registers; CTRL.start_tx reads back for one cycle only when accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q <= '0;
      cfg_q     <= '0;
      ctrl_q    <= 1'b0;
    end else begin
      if (wr_en_c && sel_tx_c)  tx_data_q <= pwdata[7:0];
      if (wr_en_c && sel_cfg_c) cfg_q     <= pwdata[4:0];
      ctrl_q <= start_req_c;
    end
  end

  // ---------------- TX engine ----------------
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [1:0]       tx_nbits_q, tx_nbits_d;
  logic             tx_stop2_q, tx_stop2_d;
  logic             tx_par_en_q, tx_par_en_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_pend_q, tx_pend_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_q, tx_d;
  logic             tx_bit_end_c;
  logic [7:0]       tx_mask_c;

  assign tx_busy_c    = (tx_state_q != ST_IDLE) | tx_pend_q;
  assign tx_bit_end_c = (tx_cnt_q == CNT_W'(BIT_CYC - 1));
  assign tx_mask_c    = 8'(8'hFF >> (2'd3 - cfg_q[1:0]));

  // TX state register and frame datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_nbits_q  <= '0;
      tx_stop2_q  <= 1'b0;
      tx_par_en_q <= 1'b0;
      tx_par_q    <= 1'b0;
      tx_pend_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_nbits_q  <= tx_nbits_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_par_en_q <= tx_par_en_d;
      tx_par_q    <= tx_par_d;
      tx_pend_q   <= tx_pend_d;
      tx_done_q   <= tx_done_d;
      tx_q        <= tx_d;
    end
  end

  // TX next state: frame and config latched on leaving IDLE, line level follows next state
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_nbits_d  = tx_nbits_q;
    tx_stop2_d  = tx_stop2_q;
    tx_par_en_d = tx_par_en_q;
    tx_par_d    = tx_par_q;
    tx_pend_d   = tx_pend_q;
    tx_done_d   = tx_done_q;
    tx_d        = 1'b1;

    if (start_req_c) begin
      tx_pend_d = 1'b1;
      tx_done_d = 1'b0;
    end

    case (tx_state_q)
      ST_IDLE: begin
        if (tx_pend_q && !cts_n) begin
          tx_state_d  = ST_START;
          tx_pend_d   = 1'b0;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_shift_d  = tx_data_q & tx_mask_c;
          tx_nbits_d  = cfg_q[1:0];
          tx_stop2_d  = cfg_q[2];
          tx_par_en_d = cfg_q[3];
          tx_par_d    = (^(tx_data_q & tx_mask_c)) ^ ~cfg_q[4];
        end
      end
      ST_START: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'(tx_nbits_q) + 3'd4) begin
            tx_bit_d   = '0;
            tx_state_d = tx_par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end_c) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_bit_end_c) begin
          tx_cnt_d = '0;
          if (tx_stop2_q && tx_bit_q == 3'd0) begin
            tx_bit_d = 3'd1;
          end else begin
            tx_bit_d   = '0;
            tx_state_d = ST_IDLE;
            tx_done_d  = 1'b1;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    case (tx_state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = tx_shift_d[0];
      ST_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx = tx_q;

  // ---------------- RX engine ----------------
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_par_q, rx_par_d;
  logic             rx_done_q, rx_done_d;
  logic             par_err_q, par_err_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic             rx_bit_end_c, rx_par_exp_c;

  assign rx_bit_end_c = (rx_cnt_q == CNT_W'(BIT_CYC - 1));
  assign rx_par_exp_c = (^rx_shift_q) ^ ~cfg_q[4];

  // RX synchronizer, state register and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_done_q  <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_done_q  <= rx_done_d;
      par_err_q  <= par_err_d;
    end
  end

  // RX next state: mid-bit sampling, glitch reject on start, framing check on stop
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_done_d  = rx_done_q;
    par_err_d  = par_err_q;

    if (rx_rd_clr_c) rx_done_d = 1'b0;

    case (rx_state_q)
      ST_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_shift_d = '0;
        end
      end
      ST_START: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_cnt_q == CNT_W'(HALF_CYC - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_bit_end_c) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_bit_q] = rx_s2_q;
          if (rx_bit_q == 3'(cfg_q[1:0]) + 3'd4) begin
            rx_state_d = cfg_q[3] ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_bit_end_c) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (rx_bit_end_c) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          if (rx_s2_q) begin
            rx_data_d = rx_shift_q;
            rx_done_d = 1'b1;
            par_err_d = cfg_q[3] & (rx_par_q != rx_par_exp_c);
          end
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  assign rts_n = rx_done_q;

  // Combinational read mux
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      if (sel_tx_c)   prdata = {24'd0, tx_data_q};
      if (sel_rx_c)   prdata = {24'd0, rx_data_q};
      if (sel_cfg_c)  prdata = {27'd0, cfg_q};
      if (sel_ctrl_c) prdata = {31'd0, ctrl_q};
      if (sel_stat_c) prdata = {28'd0, tx_busy_c, par_err_q, rx_done_q, tx_done_q};
    end
  end

endmodule

// File: tb/tb_apb_uart_top.sv
// Directed bench for apb_uart_top with a short bit period (16 clocks).
module tb_apb_uart_top;

  localparam int unsigned BIT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] paddr;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        rx, tx, cts_n, rts_n;

  int checks = 0;
  int errors = 0;

  apb_uart_top #(.BAUD_RATE(100), .FREQUENCY_CLK(1600)) dut (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .rx(rx), .tx(tx), .cts_n(cts_n), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic err, output logic rdy);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1;
    data = prdata; err = pslverr; rdy = pready;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e, r;
    apb_read(addr, d, e, r);
    check(tag, d, exp);
  endtask

  // Samples every bit of one TX frame at its centre
  task automatic check_tx_frame(input string tag, input logic [7:0] data, input int nbits,
                                input logic par_en, input logic exp_par, input int nstop);
    logic seen = 1'b0;
    for (int i = 0; i < 40 * BIT; i++) begin
      @(posedge clk); #1;
      if (!tx) begin seen = 1'b1; break; end
    end
    check({tag, "_start_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      repeat (BIT / 2) @(posedge clk);
      #1 check({tag, "_start"}, 32'(tx), 32'd0);
      for (int b = 0; b < nbits; b++) begin
        repeat (BIT) @(posedge clk);
        #1 check($sformatf("%s_d%0d", tag, b), 32'(tx), 32'(data[b]));
      end
      if (par_en) begin
        repeat (BIT) @(posedge clk);
        #1 check({tag, "_parity"}, 32'(tx), 32'(exp_par));
      end
      for (int s = 0; s < nstop; s++) begin
        repeat (BIT) @(posedge clk);
        #1 check($sformatf("%s_stop%0d", tag, s), 32'(tx), 32'd1);
      end
      repeat (BIT) @(posedge clk);
    end
  endtask

  // Drives one serial frame on rx
  task automatic send_rx(input logic [7:0] data, input int nbits, input logic par_en,
                         input logic par_bit, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      rx = data[b];
      repeat (BIT) @(negedge clk);
    end
    if (par_en) begin
      rx = par_bit;
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er, rdy;

  initial begin
    reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pstrb = '0; pwdata = '0; rx = 1'b1; cts_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rts_n", 32'(rts_n), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    reset_n = 1'b1;

    read_check("rst_status", 12'h010, 32'h0);
    apb_read(12'h014, rd, er, rdy);
    check("unmapped_pslverr", 32'(er), 32'd1);
    check("unmapped_pready", 32'(rdy), 32'd1);
    apb_read(12'h008, rd, er, rdy);
    check("mapped_pslverr", 32'(er), 32'd0);

    // 8 data bits, 1 stop, parity enabled, bit4=1 selects even
    apb_write(12'h008, 32'h1B);
    read_check("cfg_rb", 12'h008, 32'h1B);
    apb_write(12'h014, 32'h0);
    read_check("cfg_after_unmapped_wr", 12'h008, 32'h1B);

    apb_write(12'h000, 32'hA5);
    apb_write(12'h00C, 32'h1);
    check_tx_frame("txA5", 8'hA5, 8, 1'b1, 1'b0, 1);
    read_check("txA5_status", 12'h010, 32'h1);
    read_check("ctrl_selfclear", 12'h00C, 32'h0);

    apb_write(12'h000, 32'hB8);
    apb_write(12'h00C, 32'h1);
    check_tx_frame("txB8", 8'hB8, 8, 1'b1, 1'b0, 1);
    apb_write(12'h000, 32'hB9);
    apb_write(12'h00C, 32'h1);
    check_tx_frame("txB9", 8'hB9, 8, 1'b1, 1'b1, 1);
    read_check("txB9_status", 12'h010, 32'h1);

    // Held pending while remote is not ready
    cts_n = 1'b1;
    apb_write(12'h000, 32'h37);
    apb_write(12'h00C, 32'h1);
    repeat (3 * BIT) @(posedge clk);
    #1 check("cts_hold_tx", 32'(tx), 32'd1);
    read_check("cts_hold_status", 12'h010, 32'h8);
    cts_n = 1'b0;
    check_tx_frame("tx37", 8'h37, 8, 1'b1, 1'b1, 1);

    // 7 data bits, 2 stop, even parity
    apb_write(12'h008, 32'h1E);
    apb_write(12'h000, 32'h65);
    apb_write(12'h00C, 32'h1);
    check_tx_frame("tx7b", 8'h65, 7, 1'b1, 1'b0, 2);
    read_check("tx7b_status", 12'h010, 32'h1);

    // RX with a wrong parity bit: byte kept, error flagged
    apb_write(12'h008, 32'h1B);
    send_rx(8'h66, 8, 1'b1, 1'b1, 1'b1);
    read_check("rx66_status", 12'h010, 32'h7);
    #1 check("rx66_rts_n", 32'(rts_n), 32'd1);
    read_check("rx66_data", 12'h004, 32'h66);
    read_check("rx66_status_clr", 12'h010, 32'h5);
    #1 check("rx66_rts_n_clr", 32'(rts_n), 32'd0);

    send_rx(8'h3C, 8, 1'b1, 1'b0, 1'b1);
    read_check("rx3C_status", 12'h010, 32'h3);
    read_check("rx3C_data", 12'h004, 32'h3C);

    // Framing error: byte dropped
    send_rx(8'h55, 8, 1'b1, 1'b0, 1'b0);
    read_check("frame_err_status", 12'h010, 32'h1);
    read_check("frame_err_data", 12'h004, 32'h3C);

    // Short low glitch on rx
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    read_check("glitch_status", 12'h010, 32'h1);

    // Async reset mid-frame
    apb_write(12'h000, 32'h00);
    apb_write(12'h00C, 32'h1);
    repeat (2 * BIT) @(posedge clk);
    #1 check("pre_reset_tx_low", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1 check("async_reset_tx", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_check("post_reset_status", 12'h010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
